ft245_byte_if: RTL and testbench

- Byte-level controller for the FT245 asynchronous parallel FIFO between the PC (gnuradio) and the board.
- Sits directly upstream of the init/handshake FSM and the sample path.
- Converts RXF#/TXE#/RD#/WR and the bidirectional io_245 bus into two clocked 4-phase handshakes: rx_rq/rx_st for received bytes, tx_rq/tx_st for bytes to send.
- Holds one received byte and one transmit byte; arbitrates round-robin between read and write cycles.

---
 rtl/ft245_byte_if.sv | 209 ++++++++++++++++++++
 tb/tb_ft245_byte_if.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ft245_byte_if.sv
// ft245_byte_if -- byte-level controller for the FT245 asynchronous FIFO.
//
// Turns the FTDI RXF#/TXE#/RD#/WR pins and the shared io_245 bus into two
// clocked 4-phase handshakes:
//   rx_rq/rx_st : one received byte in dato_rx, held until acknowledged
//   tx_rq/tx_st : one byte from dato_tx, latched at grant and written out
// Read and write bus cycles are arbitrated round-robin. After every bus
// cycle a RECOVER gap lets the synchronised flags catch up.
//
// Ports:
//   clk, rst          system clock, synchronous active-high reset
//   io_245[7:0]       FTDI data bus (driven only during a write)
//   rxf_245, txe_245  FTDI RXF#/TXE# (async, low = ready)
//   rx_245, wr_245    FTDI RD# (active low), WR (active high)
//   rx_rq, dato_rx,   receive handshake towards the consumer
//   rx_st
//   tx_rq, dato_tx,   transmit handshake from the producer
//   tx_st
//   led_rx, led_tx    activity LEDs
//
// Optional: define FT245_ACT_LED_EN to stretch each rx/tx byte event into
// LED_HOLD_CYC cycles on the LEDs; otherwise the LEDs are tied low.
module ft245_byte_if #(
  parameter int SYNC_STAGES  = 2,
  parameter int RD_LOW_CYC   = 4,
  parameter int WR_SETUP_CYC = 2,
  parameter int WR_HIGH_CYC  = 3,
  parameter int RECOVERY_CYC = 3,
  parameter int LED_HOLD_CYC = 2400000
) (
  input  logic       clk,
  input  logic       rst,
  inout  wire  [7:0] io_245,
  input  logic       rxf_245,
  input  logic       txe_245,
  output logic       rx_245,
  output logic       wr_245,
  output logic       rx_rq,
  output logic [7:0] dato_rx,
  input  logic       rx_st,
  input  logic       tx_rq,
  input  logic [7:0] dato_tx,
  output logic       tx_st,
  output logic       led_rx,
  output logic       led_tx
);

  if (SYNC_STAGES < 2) begin : g_chk_sync
    $error("SYNC_STAGES must be at least 2");
  end
  if (RECOVERY_CYC < SYNC_STAGES + 1) begin : g_chk_rec
    $error("RECOVERY_CYC must be at least SYNC_STAGES+1");
  end
  if (RD_LOW_CYC < 1 || WR_SETUP_CYC < 1 || WR_HIGH_CYC < 1 ||
      RD_LOW_CYC > 256 || WR_SETUP_CYC > 256 || WR_HIGH_CYC > 256 ||
      RECOVERY_CYC > 256) begin : g_chk_cyc
    $error("bus timing parameters must be in 1..256");
  end
  if (LED_HOLD_CYC < 1 || LED_HOLD_CYC > 4194304) begin : g_chk_led
    $error("LED_HOLD_CYC must fit a 22-bit counter");
  end

  typedef enum logic [2:0] {
    IDLE, RD_LOW, TX_SETUP, TX_STROBE, TX_HOLD, RECOVER
  } state_t;

  state_t                 state;
  logic [7:0]             cnt;
  logic [SYNC_STAGES-1:0] rxf_sync, txe_sync;
  logic                   rxf_s, txe_s, rd_ok, wr_ok;
  logic                   prefer_rx;   // side that wins the next tie
  logic                   bus_oe;
  logic [7:0]             tx_buf;

  // Flags reset to the inactive (high) level so nothing starts until the
  // pins have really been seen low.
  always_ff @(posedge clk) begin
    if (rst) begin
      rxf_sync <= '1;
      txe_sync <= '1;
    end else begin
      rxf_sync <= {rxf_sync[SYNC_STAGES-2:0], rxf_245};
      txe_sync <= {txe_sync[SYNC_STAGES-2:0], txe_245};
    end
  end

  assign rxf_s = rxf_sync[SYNC_STAGES-1];
  assign txe_s = txe_sync[SYNC_STAGES-1];
  assign rd_ok = !rxf_s && !rx_rq && !rx_st;
  assign wr_ok = !txe_s && tx_rq && !tx_st;

  assign io_245 = bus_oe ? tx_buf : 8'hzz;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      rx_245    <= 1'b1;
      wr_245    <= 1'b0;
      bus_oe    <= 1'b0;
      tx_buf    <= '0;
      rx_rq     <= 1'b0;
      dato_rx   <= '0;
      tx_st     <= 1'b0;
      prefer_rx <= 1'b1;
    end else begin
      // Handshake release runs regardless of the bus state.
      if (rx_rq && rx_st) rx_rq <= 1'b0;
      if (tx_st && !tx_rq) tx_st <= 1'b0;

      case (state)
        IDLE: begin
          if (rd_ok && (prefer_rx || !wr_ok)) begin
            state     <= RD_LOW;
            rx_245    <= 1'b0;
            cnt       <= 8'(RD_LOW_CYC - 1);
            prefer_rx <= 1'b0;
          end else if (wr_ok) begin
            state     <= TX_SETUP;
            tx_buf    <= dato_tx;
            bus_oe    <= 1'b1;
            cnt       <= 8'(WR_SETUP_CYC - 1);
            prefer_rx <= 1'b1;
          end
        end
        RD_LOW: begin
          if (cnt == 8'd0) begin
            // FTDI data is valid well before the end of the RD# pulse.
            dato_rx <= io_245;
            rx_rq   <= 1'b1;
            rx_245  <= 1'b1;
            state   <= RECOVER;
            cnt     <= 8'(RECOVERY_CYC - 1);
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        TX_SETUP: begin
          if (cnt == 8'd0) begin
            wr_245 <= 1'b1;
            state  <= TX_STROBE;
            cnt    <= 8'(WR_HIGH_CYC - 1);
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        TX_STROBE: begin
          if (cnt == 8'd0) begin
            wr_245 <= 1'b0;   // FTDI latches here; bus held one more cycle
            state  <= TX_HOLD;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        TX_HOLD: begin
          bus_oe <= 1'b0;
          tx_st  <= 1'b1;
          state  <= RECOVER;
          cnt    <= 8'(RECOVERY_CYC - 1);
        end
        RECOVER: begin
          if (cnt == 8'd0) state <= IDLE;
          else             cnt <= cnt - 8'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef FT245_ACT_LED_EN
  logic        rx_rq_q, tx_st_q;
  logic [21:0] led_rx_cnt, led_tx_cnt;

  // A rising rx_rq marks a capture, a rising tx_st a completed write.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_rq_q    <= 1'b0;
      tx_st_q    <= 1'b0;
      led_rx     <= 1'b0;
      led_tx     <= 1'b0;
      led_rx_cnt <= '0;
      led_tx_cnt <= '0;
    end else begin
      rx_rq_q <= rx_rq;
      tx_st_q <= tx_st;
      if (rx_rq && !rx_rq_q) begin
        led_rx     <= 1'b1;
        led_rx_cnt <= 22'(LED_HOLD_CYC - 1);
      end else if (led_rx_cnt != '0) begin
        led_rx_cnt <= led_rx_cnt - 22'd1;
      end else begin
        led_rx <= 1'b0;
      end
      if (tx_st && !tx_st_q) begin
        led_tx     <= 1'b1;
        led_tx_cnt <= 22'(LED_HOLD_CYC - 1);
      end else if (led_tx_cnt != '0) begin
        led_tx_cnt <= led_tx_cnt - 22'd1;
      end else begin
        led_tx <= 1'b0;
      end
    end
  end
`else
  assign led_rx = 1'b0;
  assign led_tx = 1'b0;
`endif

endmodule

// File: tb/tb_ft245_byte_if.sv
module tb_ft245_byte_if;
  logic       clk = 1'b0;
  logic       rst, rxf_245, txe_245, rx_st, tx_rq;
  logic [7:0] dato_tx, rx_byte;
  logic       rx_245, wr_245, rx_rq, tx_st, led_rx, led_tx;
  logic [7:0] dato_rx;
  wire  [7:0] io_245;
  int         total = 0, bad = 0;
  logic       alt_en = 1'b0;

  always #5 clk = ~clk;

  // FTDI side: drives the bus while RD# is low; pulldowns make a released
  // bus read as 0x00.
  assign io_245 = rx_245 ? 8'hzz : rx_byte;
  for (genvar g = 0; g < 8; g++) begin : g_pd
    pulldown (io_245[g]);
  end

  ft245_byte_if dut (
    .clk(clk), .rst(rst), .io_245(io_245), .rxf_245(rxf_245),
    .txe_245(txe_245), .rx_245(rx_245), .wr_245(wr_245), .rx_rq(rx_rq),
    .dato_rx(dato_rx), .rx_st(rx_st), .tx_rq(tx_rq), .dato_tx(dato_tx),
    .tx_st(tx_st), .led_rx(led_rx), .led_tx(led_tx)
  );

  // Pin monitor, sampled on the falling edge.
  int         rd_len = 0, wr_len = 0, rd_pulses = 0, wr_pulses = 0;
  int         last_rd_len = 0, last_wr_len = 0;
  int         overlap_err = 0, bus_err = 0, order_err = 0, wr_bus_bad = 0, alt_err = 0;
  int         last_kind = 0;
  logic       alt_en_q = 1'b0;
  logic [7:0] wb = '0, last_wr_byte = '0;

  always @(negedge clk) begin
    if (alt_en && !alt_en_q) last_kind = 0;
    alt_en_q = alt_en;
    if (rx_245 === 1'b0) begin
      if (rd_len == 0) begin
        if (rx_rq !== 1'b0 || rx_st !== 1'b0) order_err++;
        if (alt_en) begin
          if (last_kind == 1) alt_err++;
          last_kind = 1;
        end
      end
      rd_len++;
      if (io_245 !== rx_byte) bus_err++;
      if (wr_245 === 1'b1) overlap_err++;
    end else if (rd_len != 0) begin
      rd_pulses++;
      last_rd_len = rd_len;
      rd_len = 0;
    end
    if (wr_245 === 1'b1) begin
      if (wr_len == 0) begin
        wb = io_245;
        if (alt_en) begin
          if (last_kind == 2) alt_err++;
          last_kind = 2;
        end
      end else if (io_245 !== wb) begin
        wr_bus_bad++;
      end
      wr_len++;
    end else if (wr_len != 0) begin
      wr_pulses++;
      last_wr_len = wr_len;
      last_wr_byte = wb;
      wr_len = 0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_rx(output int n);
    n = 0;
    while (rx_rq !== 1'b1 && n < 30) begin step(); n++; end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, drv, badb, rp0, wp0;
    logic [7:0] bytes [3];
    bytes[0] = 8'h55; bytes[1] = 8'h54; bytes[2] = 8'h4E;

    rst = 1'b1; rxf_245 = 1'b1; txe_245 = 1'b1; rx_st = 1'b0; tx_rq = 1'b0;
    dato_tx = 8'h00; rx_byte = 8'h00;
    repeat (3) step();
    chk("rst_rd",     rx_245, 1);
    chk("rst_wr",     wr_245, 0);
    chk("rst_bus",    io_245, 8'h00);
    chk("rst_rx_rq",  rx_rq, 0);
    chk("rst_dato",   dato_rx, 8'h00);
    chk("rst_tx_st",  tx_st, 0);
    chk("rst_leds",   {led_rx, led_tx}, 2'b00);
    rst = 1'b0;
    repeat (3) step();

    // 1: single byte 'U', ack two cycles after rx_rq.
    rp0 = rd_pulses;
    rx_byte = 8'h55; rxf_245 = 1'b0;
    wait_rx(n);
    chk("t1_rx_rq", rx_rq, 1);
    chk("t1_latency_ok", (n >= 7 && n <= 8), 1);
    chk("t1_dato", dato_rx, 8'h55);
    chk("t1_rd_high", rx_245, 1);
    rxf_245 = 1'b1;
    step(); step();
    rx_st = 1'b1;
    step();
    chk("t1_rq_fall", rx_rq, 0);
    rx_st = 1'b0;
    repeat (20) step();
    chk("t1_rd_pulses", rd_pulses - rp0, 1);
    chk("t1_rd_len", last_rd_len, 4);
    chk("t1_rd_idle", rx_245, 1);

    // 2: three bytes with RXF# held low, slow consumer.
    rp0 = rd_pulses;
    rxf_245 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rx_byte = bytes[i];
      wait_rx(n);
      chk("t2_rx_rq", rx_rq, 1);
      chk("t2_dato", dato_rx, bytes[i]);
      if (i == 2) rxf_245 = 1'b1;
      rx_byte = 8'hEE;
      repeat (20) step();
      chk("t2_dato_hold", dato_rx, bytes[i]);
      chk("t2_rq_hold", rx_rq, 1);
      rx_st = 1'b1;
      step();
      chk("t2_rq_fall", rx_rq, 0);
      rx_st = 1'b0;
    end
    repeat (15) step();
    chk("t2_rd_pulses", rd_pulses - rp0, 3);
    chk("t2_order", order_err, 0);

    // 3: write 'v', dato_tx changes right after grant.
    txe_245 = 1'b0;
    repeat (4) step();
    wp0 = wr_pulses;
    dato_tx = 8'h76; tx_rq = 1'b1;
    step();
    dato_tx = 8'h00;
    n = 0; drv = 0; badb = 0;
    while (tx_st !== 1'b1 && n < 12) begin
      if (io_245 !== 8'h00) begin
        drv++;
        if (io_245 !== 8'h76) badb++;
      end
      step(); n++;
    end
    chk("t3_tx_st", tx_st, 1);
    chk("t3_latency_ok", (n + 1 >= 7 && n + 1 <= 8), 1);
    chk("t3_drive_cycles", drv, 6);
    chk("t3_bus_value", badb, 0);
    chk("t3_bus_released", io_245, 8'h00);
    repeat (3) step();
    chk("t3_st_hold", tx_st, 1);
    tx_rq = 1'b0;
    step();
    chk("t3_st_fall", tx_st, 0);
    step();
    chk("t3_wr_pulses", wr_pulses - wp0, 1);
    chk("t3_wr_len", last_wr_len, 3);
    chk("t3_wr_byte", last_wr_byte, 8'h76);
    chk("t3_wr_stable", wr_bus_bad, 0);

    // 4: TXE# high blocks the write, then releases it.
    txe_245 = 1'b1;
    repeat (4) step();
    wp0 = wr_pulses;
    dato_tx = 8'hA5; tx_rq = 1'b1;
    drv = 0;
    repeat (100) begin
      step();
      if (wr_245 !== 1'b0 || io_245 !== 8'h00) drv++;
    end
    chk("t4_blocked", drv, 0);
    chk("t4_no_st", tx_st, 0);
    txe_245 = 1'b0;
    n = 0;
    while (tx_st !== 1'b1 && n < 15) begin step(); n++; end
    chk("t4_tx_st", tx_st, 1);
    chk("t4_latency_ok", (n >= 8 && n <= 10), 1);
    tx_rq = 1'b0;
    step(); step();
    chk("t4_wr_byte", last_wr_byte, 8'hA5);
    chk("t4_wr_pulses", wr_pulses - wp0, 1);

    // 5: both sides busy -> strict alternation.
    rp0 = rd_pulses; wp0 = wr_pulses;
    rx_byte = 8'h3C; rxf_245 = 1'b0;
    dato_tx = 8'hC3; tx_rq = 1'b1;
    alt_en = 1'b1;
    repeat (300) begin
      step();
      if (rx_rq && !rx_st) rx_st = 1'b1;
      else if (!rx_rq && rx_st) rx_st = 1'b0;
      if (tx_st && tx_rq) tx_rq = 1'b0;
      else if (!tx_st && !tx_rq) begin tx_rq = 1'b1; dato_tx = dato_tx + 8'd1; end
    end
    rxf_245 = 1'b1; txe_245 = 1'b1;
    repeat (40) begin
      step();
      if (rx_rq && !rx_st) rx_st = 1'b1;
      else if (!rx_rq && rx_st) rx_st = 1'b0;
      if (tx_st && tx_rq) tx_rq = 1'b0;
    end
    alt_en = 1'b0;
    step();
    chk("t5_alternate", alt_err, 0);
    chk("t5_overlap", overlap_err, 0);
    chk("t5_bus_contention", bus_err, 0);
    chk("t5_enough_reads", (rd_pulses - rp0 >= 10), 1);
    chk("t5_balanced", ((rd_pulses - rp0) - (wr_pulses - wp0) <= 1 &&
                        (wr_pulses - wp0) - (rd_pulses - rp0) <= 1), 1);
    chk("t5_idle_hs", {rx_rq, tx_st}, 2'b00);

    // 6a: reset in the 2nd cycle of RD_LOW.
    rx_byte = 8'h11; rxf_245 = 1'b0;
    n = 0;
    while (rx_245 !== 1'b0 && n < 15) begin step(); n++; end
    chk("t6_rd_start", rx_245, 0);
    step();
    rst = 1'b1;
    step();
    chk("t6a_rd", rx_245, 1);
    chk("t6a_wr", wr_245, 0);
    chk("t6a_bus", io_245, 8'h00);
    chk("t6a_rx_rq", rx_rq, 0);
    chk("t6a_dato", dato_rx, 8'h00);
    chk("t6a_tx_st", tx_st, 0);
    rst = 1'b0; rxf_245 = 1'b1;
    repeat (10) step();
    chk("t6a_idle", {rx_245, rx_rq}, 2'b10);

    // 6b: reset in the 3rd cycle of TX_STROBE.
    txe_245 = 1'b0;
    repeat (4) step();
    dato_tx = 8'h99; tx_rq = 1'b1;
    n = 0;
    while (wr_245 !== 1'b1 && n < 15) begin step(); n++; end
    chk("t6_wr_start", wr_245, 1);
    step(); step();
    rst = 1'b1;
    step();
    chk("t6b_wr", wr_245, 0);
    chk("t6b_bus", io_245, 8'h00);
    chk("t6b_tx_st", tx_st, 0);
    chk("t6b_rd", rx_245, 1);
    chk("t6b_rx_rq", rx_rq, 0);
    rst = 1'b0; tx_rq = 1'b0;
    repeat (10) step();
    chk("t6b_no_st", tx_st, 0);
    chk("t6b_wr_idle", wr_245, 0);

    chk("end_overlap", overlap_err, 0);
    chk("end_leds", {led_rx, led_tx}, 2'b00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
